debug_uart_tx: RTL and testbench



---
 rtl/debug_uart_tx.sv | 162 ++++++++++++++++
 tb/tb_debug_uart_tx.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_uart_tx.sv
// Buffered 8N1 debug UART transmitter: byte FIFO fed by single-cycle send strobes,
// drained by a start/data/stop serialiser with a sticky overflow flag.
module debug_uart_tx #(
  parameter int CLKS_PER_BIT = 234,
  parameter int DEPTH        = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   send,
  input  logic [7:0]             data,
  output logic                   uart_tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]        mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        shift;
  logic [7:0]        shift_nxt;
  logic [2:0]        bit_idx;
  logic [2:0]        bit_nxt;
  logic [BAUD_W-1:0] baud;
  logic [BAUD_W-1:0] baud_nxt;
  logic              tx_nxt;

  // The full test uses the pre-edge level, so a pop on the same edge cannot rescue a write.
  assign full  = (fifo_level == LVL_FULL);
  assign empty = (fifo_level == '0);
  assign push  = send & ~full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (send && full) begin
        overflow <= 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    bit_nxt   = bit_idx;
    baud_nxt  = baud;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          bit_nxt   = '0;
          baud_nxt  = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (baud == BAUD_LAST) begin
          baud_nxt  = '0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          baud_nxt  = '0;
          shift_nxt = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_idx + 3'd1;
          end
        end else begin
          baud_nxt = baud + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud == BAUD_LAST) begin
          baud_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          baud_nxt = baud + BAUD_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // The line level is registered from the upcoming state so uart_tx is glitch-free.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_idx <= '0;
      baud    <= '0;
      uart_tx <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_idx <= bit_nxt;
      baud    <= baud_nxt;
      uart_tx <= tx_nxt;
      busy    <= (state != IDLE) | (fifo_level != '0);
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_nxt;
  end

endmodule

// File: tb/tb_debug_uart_tx.sv
// Bench for debug_uart_tx: a small instance (DEPTH=4, 4 clocks/bit) against a timer-based
// reference model and line decoder, plus a default-sized instance fed the debug sequence.
module tb_debug_uart_tx;

  localparam int CA = 4;
  localparam int DA = 4;
  localparam int CD = 234;
  localparam int DD = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       send_a = 1'b0;
  logic [7:0] data_a = 8'h00;
  logic       tx_a, busy_a, ovf_a;
  logic [2:0] lvl_a;
  logic       send_d = 1'b0;
  logic [7:0] data_d = 8'h00;
  logic       tx_d, busy_d, ovf_d;
  logic [5:0] lvl_d;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  debug_uart_tx #(.CLKS_PER_BIT(CA), .DEPTH(DA)) u_a (
    .clk(clk), .reset(reset), .send(send_a), .data(data_a),
    .uart_tx(tx_a), .busy(busy_a), .fifo_level(lvl_a), .overflow(ovf_a)
  );

  debug_uart_tx #(.CLKS_PER_BIT(CD), .DEPTH(DD)) u_d (
    .clk(clk), .reset(reset), .send(send_d), .data(data_d),
    .uart_tx(tx_d), .busy(busy_d), .fifo_level(lvl_d), .overflow(ovf_d)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: a queue of accepted bytes and a frame timer of 10*CA clocks.
  int         m_lvl = 0;
  int         m_timer = 0;
  bit         m_ovf = 1'b0;
  bit         m_busy = 1'b0;
  bit         m_pop, m_take;
  logic [7:0] m_cur = 8'h00;
  logic [7:0] m_q[$];
  logic [7:0] m_acc[$];

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_lvl = 0; m_timer = 0; m_ovf = 1'b0; m_busy = 1'b0;
      m_q.delete();
    end else begin
      m_busy = (m_timer > 0) || (m_lvl > 0);
      m_pop  = (m_timer == 0) && (m_lvl > 0);
      m_take = send_a && (m_lvl < DA);
      if (send_a && !m_take) m_ovf = 1'b1;
      if (m_pop) begin
        m_cur = m_q.pop_front();
        m_timer = 10 * CA;
      end else if (m_timer > 0) begin
        m_timer--;
      end
      if (m_take) begin
        m_q.push_back(data_a);
        m_acc.push_back(data_a);
      end
      m_lvl = m_lvl + int'(m_take) - int'(m_pop);
    end
  end

  function automatic logic exp_tx();
    int e, b;
    if (m_timer == 0) return 1'b1;
    e = 10 * CA - m_timer;
    b = e / CA;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  // Line decoders sampling mid-bit at the nominal rate.
  bit         da_act = 1'b0;
  int         da_cnt, da_bit, da_ferr = 0;
  logic [7:0] da_sr;
  logic [7:0] da_rx[$];
  int         da_start[$];

  initial forever begin
    @(negedge clk);
    if (reset) begin
      da_act = 1'b0;
    end else if (!da_act) begin
      if (!tx_a) begin
        da_act = 1'b1; da_cnt = CA / 2; da_bit = 0;
        da_start.push_back(cyc);
      end
    end else begin
      da_cnt--;
      if (da_cnt == 0) begin
        if (da_bit == 0) begin
          if (tx_a) da_ferr++;
        end else if (da_bit <= 8) begin
          da_sr[da_bit-1] = tx_a;
        end else begin
          if (!tx_a) da_ferr++;
          da_rx.push_back(da_sr);
          da_act = 1'b0;
        end
        da_bit++;
        da_cnt = CA;
      end
    end
  end

  bit         dd_act = 1'b0;
  int         dd_cnt, dd_bit, dd_ferr = 0;
  logic [7:0] dd_sr;
  logic [7:0] dd_rx[$];
  int         dd_start[$];

  initial forever begin
    @(negedge clk);
    if (reset) begin
      dd_act = 1'b0;
    end else if (!dd_act) begin
      if (!tx_d) begin
        dd_act = 1'b1; dd_cnt = CD / 2; dd_bit = 0;
        dd_start.push_back(cyc);
      end
    end else begin
      dd_cnt--;
      if (dd_cnt == 0) begin
        if (dd_bit == 0) begin
          if (tx_d) dd_ferr++;
        end else if (dd_bit <= 8) begin
          dd_sr[dd_bit-1] = tx_d;
        end else begin
          if (!tx_d) dd_ferr++;
          dd_rx.push_back(dd_sr);
          dd_act = 1'b0;
        end
        dd_bit++;
        dd_cnt = CD;
      end
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1; send_a = 1'b0; send_d = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_acc.delete(); da_rx.delete(); da_start.delete(); da_ferr = 0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({tx_a, busy_a, lvl_a, ovf_a} !== {1'b1, 1'b0, 3'd0, 1'b0})
      $display("FAIL reset_async got tx,busy,lvl,ovf=%b,%b,%0d,%b want 1,0,0,0", tx_a, busy_a, lvl_a, ovf_a);
    else n_pass++;
    n_checks++;
    if ({tx_d, busy_d, lvl_d, ovf_d} !== {1'b1, 1'b0, 6'd0, 1'b0})
      $display("FAIL reset_dbg got tx,busy,lvl,ovf=%b,%b,%0d,%b want 1,0,0,0", tx_d, busy_d, lvl_d, ovf_d);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx_a, busy_a, lvl_a, ovf_a} !== {1'b1, 1'b0, 3'd0, 1'b0})
      $display("FAIL reset_idle got tx,busy,lvl,ovf=%b,%b,%0d,%b want 1,0,0,0", tx_a, busy_a, lvl_a, ovf_a);
    else n_pass++;
  endtask

  task automatic test_single_byte();
    bit pat [10] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 1};
    reset_dut();
    @(negedge clk);
    send_a = 1'b1; data_a = 8'h44;
    @(negedge clk);
    send_a = 1'b0;
    n_checks++;
    if ({tx_a, lvl_a} !== {1'b1, 3'd1})
      $display("FAIL single_queued got tx,lvl=%b,%0d want 1,1", tx_a, lvl_a);
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_checks++;
      if (tx_a !== pat[i/4]) $display("FAIL single_bit%0d got tx=%b want %b", i, tx_a, pat[i/4]);
      else n_pass++;
      n_checks++;
      if ({tx_a, busy_a, lvl_a, ovf_a} !== {exp_tx(), m_busy, 3'(m_lvl), m_ovf})
        $display("FAIL single_cyc%0d got tx,busy,lvl,ovf=%b,%b,%0d,%b want %b,%b,%0d,%b",
                 cyc, tx_a, busy_a, lvl_a, ovf_a, exp_tx(), m_busy, m_lvl, m_ovf);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if ({tx_a, busy_a} !== 2'b11) $display("FAIL single_after_stop got tx,busy=%b,%b want 1,1", tx_a, busy_a);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b0) $display("FAIL single_busy_fall got busy=%b want 0", busy_a);
    else n_pass++;
  endtask

  task automatic test_burst();
    int maxlvl = 0;
    reset_dut();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if ({tx_a, busy_a, lvl_a, ovf_a} !== {exp_tx(), m_busy, 3'(m_lvl), m_ovf})
        $display("FAIL burst_cyc%0d got tx,busy,lvl,ovf=%b,%b,%0d,%b want %b,%b,%0d,%b",
                 cyc, tx_a, busy_a, lvl_a, ovf_a, exp_tx(), m_busy, m_lvl, m_ovf);
      else n_pass++;
      if (k == 2) begin
        n_checks++;
        if ({tx_a, lvl_a} !== {1'b0, 3'd1}) $display("FAIL burst_first_pop got tx,lvl=%b,%0d want 0,1", tx_a, lvl_a);
        else n_pass++;
      end
      if (int'(lvl_a) > maxlvl) maxlvl = int'(lvl_a);
      send_a = (k < 5);
      data_a = 8'(k + 1);
    end
    for (int i = 0; i < 400 && (busy_a || m_timer > 0 || m_lvl > 0); i++) begin
      @(negedge clk);
      n_checks++;
      if ({tx_a, busy_a, lvl_a, ovf_a} !== {exp_tx(), m_busy, 3'(m_lvl), m_ovf})
        $display("FAIL burst_cyc%0d got tx,busy,lvl,ovf=%b,%b,%0d,%b want %b,%b,%0d,%b",
                 cyc, tx_a, busy_a, lvl_a, ovf_a, exp_tx(), m_busy, m_lvl, m_ovf);
      else n_pass++;
    end
    n_checks++;
    if (busy_a !== 1'b0) $display("FAIL burst_drain_timeout got busy=%b want 0", busy_a);
    else n_pass++;
    n_checks++;
    if ({maxlvl, ovf_a} !== {32'd4, 1'b0}) $display("FAIL burst_fill got maxlvl,ovf=%0d,%b want 4,0", maxlvl, ovf_a);
    else n_pass++;
    n_checks++;
    if (da_rx.size() != 5 || da_ferr != 0)
      $display("FAIL burst_count got frames,ferr=%0d,%0d want 5,0", da_rx.size(), da_ferr);
    else n_pass++;
    for (int i = 0; i < 5 && i < da_rx.size(); i++) begin
      n_checks++;
      if (da_rx[i] !== 8'(i + 1)) $display("FAIL burst_byte%0d got %h want %h", i, da_rx[i], 8'(i + 1));
      else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (da_start[i] - da_start[i-1] != 41)
          $display("FAIL burst_period%0d got %0d want 41", i, da_start[i] - da_start[i-1]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] want [5] = '{8'h9F, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
    reset_dut();
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      n_checks++;
      if ({tx_a, busy_a, lvl_a, ovf_a} !== {exp_tx(), m_busy, 3'(m_lvl), m_ovf})
        $display("FAIL ovf_cyc%0d got tx,busy,lvl,ovf=%b,%b,%0d,%b want %b,%b,%0d,%b",
                 cyc, tx_a, busy_a, lvl_a, ovf_a, exp_tx(), m_busy, m_lvl, m_ovf);
      else n_pass++;
      if (k == 7) begin
        n_checks++;
        if ({lvl_a, ovf_a} !== {3'd4, 1'b0}) $display("FAIL ovf_full got lvl,ovf=%0d,%b want 4,0", lvl_a, ovf_a);
        else n_pass++;
      end
      if (k >= 8) begin
        n_checks++;
        if ({lvl_a, ovf_a} !== {3'd4, 1'b1}) $display("FAIL ovf_drop got lvl,ovf=%0d,%b want 4,1", lvl_a, ovf_a);
        else n_pass++;
      end
      send_a = (k == 0) || (k >= 3 && k <= 8);
      data_a = (k == 0) ? 8'h9F : 8'(8'hA0 + k - 3);
    end
    for (int i = 0; i < 400 && (busy_a || m_timer > 0 || m_lvl > 0); i++) begin
      @(negedge clk);
      n_checks++;
      if ({tx_a, busy_a, lvl_a, ovf_a} !== {exp_tx(), m_busy, 3'(m_lvl), m_ovf})
        $display("FAIL ovf_cyc%0d got tx,busy,lvl,ovf=%b,%b,%0d,%b want %b,%b,%0d,%b",
                 cyc, tx_a, busy_a, lvl_a, ovf_a, exp_tx(), m_busy, m_lvl, m_ovf);
      else n_pass++;
    end
    n_checks++;
    if (da_rx.size() != 5 || da_ferr != 0 || ovf_a !== 1'b1)
      $display("FAIL ovf_frames got frames,ferr,ovf=%0d,%0d,%b want 5,0,1", da_rx.size(), da_ferr, ovf_a);
    else n_pass++;
    for (int i = 0; i < 5 && i < da_rx.size(); i++) begin
      n_checks++;
      if (da_rx[i] !== want[i]) $display("FAIL ovf_byte%0d got %h want %h", i, da_rx[i], want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_full_pop();
    bit found = 1'b0;
    reset_dut();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      send_a = (k < 5);
      data_a = 8'(8'hB0 + k);
    end
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      n_checks++;
      if ({tx_a, busy_a, lvl_a, ovf_a} !== {exp_tx(), m_busy, 3'(m_lvl), m_ovf})
        $display("FAIL fullpop_cyc%0d got tx,busy,lvl,ovf=%b,%b,%0d,%b want %b,%b,%0d,%b",
                 cyc, tx_a, busy_a, lvl_a, ovf_a, exp_tx(), m_busy, m_lvl, m_ovf);
      else n_pass++;
      if (m_timer == 0 && m_lvl == 4) begin
        found = 1'b1;
        send_a = 1'b1; data_a = 8'h77;
      end
    end
    n_checks++;
    if (!found || lvl_a !== 3'd4 || ovf_a !== 1'b0)
      $display("FAIL fullpop_setup got found,lvl,ovf=%b,%0d,%b want 1,4,0", found, lvl_a, ovf_a);
    else n_pass++;
    @(negedge clk);
    send_a = 1'b0;
    n_checks++;
    if ({lvl_a, ovf_a} !== {3'd3, 1'b1}) $display("FAIL fullpop_drop got lvl,ovf=%0d,%b want 3,1", lvl_a, ovf_a);
    else n_pass++;
    for (int i = 0; i < 400 && (busy_a || m_timer > 0 || m_lvl > 0); i++) begin
      @(negedge clk);
      n_checks++;
      if ({tx_a, busy_a, lvl_a, ovf_a} !== {exp_tx(), m_busy, 3'(m_lvl), m_ovf})
        $display("FAIL fullpop_cyc%0d got tx,busy,lvl,ovf=%b,%b,%0d,%b want %b,%b,%0d,%b",
                 cyc, tx_a, busy_a, lvl_a, ovf_a, exp_tx(), m_busy, m_lvl, m_ovf);
      else n_pass++;
    end
    n_checks++;
    if (da_rx.size() != 5) $display("FAIL fullpop_frames got %0d want 5", da_rx.size());
    else n_pass++;
    for (int i = 0; i < 5 && i < da_rx.size(); i++) begin
      n_checks++;
      if (da_rx[i] !== 8'(8'hB0 + i)) $display("FAIL fullpop_byte%0d got %h want %h", i, da_rx[i], 8'(8'hB0 + i));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      send_a = (k < 3);
      data_a = (k == 0) ? 8'h55 : (k == 1) ? 8'h11 : 8'h22;
    end
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (m_timer > 0 && (10 * CA - m_timer) / CA == 4) found = 1'b1;
    end
    n_checks++;
    if (!found || tx_a !== 1'b0 || lvl_a !== 3'd2)
      $display("FAIL rstmid_setup got found,tx,lvl=%b,%b,%0d want 1,0,2", found, tx_a, lvl_a);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({tx_a, busy_a, lvl_a, ovf_a} !== {1'b1, 1'b0, 3'd0, 1'b0})
      $display("FAIL rstmid_async got tx,busy,lvl,ovf=%b,%b,%0d,%b want 1,0,0,0", tx_a, busy_a, lvl_a, ovf_a);
    else n_pass++;
    @(negedge clk);
    #2 reset = 1'b0;
    m_acc.delete(); da_rx.delete(); da_start.delete(); da_ferr = 0;
    @(negedge clk);
    send_a = 1'b1; data_a = 8'h0D;
    @(negedge clk);
    send_a = 1'b0;
    for (int i = 0; i < 400 && (busy_a || m_timer > 0 || m_lvl > 0); i++) begin
      @(negedge clk);
      n_checks++;
      if ({tx_a, busy_a, lvl_a, ovf_a} !== {exp_tx(), m_busy, 3'(m_lvl), m_ovf})
        $display("FAIL rstmid_cyc%0d got tx,busy,lvl,ovf=%b,%b,%0d,%b want %b,%b,%0d,%b",
                 cyc, tx_a, busy_a, lvl_a, ovf_a, exp_tx(), m_busy, m_lvl, m_ovf);
      else n_pass++;
    end
    n_checks++;
    if (da_rx.size() != 1 || da_ferr != 0)
      $display("FAIL rstmid_frames got frames,ferr=%0d,%0d want 1,0", da_rx.size(), da_ferr);
    else if (da_rx[0] !== 8'h0D) $display("FAIL rstmid_byte got %h want 0d", da_rx[0]);
    else n_pass++;
  endtask

  task automatic test_random();
    reset_dut();
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      n_checks++;
      if ({tx_a, busy_a, lvl_a, ovf_a} !== {exp_tx(), m_busy, 3'(m_lvl), m_ovf})
        $display("FAIL rand_cyc%0d got tx,busy,lvl,ovf=%b,%b,%0d,%b want %b,%b,%0d,%b",
                 cyc, tx_a, busy_a, lvl_a, ovf_a, exp_tx(), m_busy, m_lvl, m_ovf);
      else n_pass++;
      send_a = ($urandom_range(0, 99) < 15);
      data_a = 8'($urandom);
    end
    @(negedge clk);
    send_a = 1'b0;
    for (int i = 0; i < 600 && (busy_a || m_timer > 0 || m_lvl > 0); i++) begin
      @(negedge clk);
      n_checks++;
      if ({tx_a, busy_a, lvl_a, ovf_a} !== {exp_tx(), m_busy, 3'(m_lvl), m_ovf})
        $display("FAIL rand_cyc%0d got tx,busy,lvl,ovf=%b,%b,%0d,%b want %b,%b,%0d,%b",
                 cyc, tx_a, busy_a, lvl_a, ovf_a, exp_tx(), m_busy, m_lvl, m_ovf);
      else n_pass++;
    end
    n_checks++;
    if (da_rx.size() != m_acc.size() || da_ferr != 0 || busy_a !== 1'b0)
      $display("FAIL rand_frames got frames,ferr,busy=%0d,%0d,%b want %0d,0,0", da_rx.size(), da_ferr, busy_a, m_acc.size());
    else n_pass++;
    for (int i = 0; i < da_rx.size() && i < m_acc.size(); i++) begin
      n_checks++;
      if (da_rx[i] !== m_acc[i]) $display("FAIL rand_byte%0d got %h want %h", i, da_rx[i], m_acc[i]);
      else n_pass++;
    end
  endtask

  task automatic test_debug_sequence();
    logic [7:0] seq[$];
    seq = '{8'h44, 8'h42, 8'h47, 8'h3A, 8'h20};
    for (int i = 0; i < 16; i++) seq.push_back(8'(i));
    seq.push_back(8'h0D);
    seq.push_back(8'h0A);
    dd_rx.delete(); dd_start.delete(); dd_ferr = 0;
    for (int i = 0; i < seq.size(); i++) begin
      @(negedge clk);
      send_d = 1'b1; data_d = seq[i];
      @(negedge clk);
      send_d = 1'b0;
      repeat (14) @(negedge clk);
    end
    n_checks++;
    if (ovf_d !== 1'b0) $display("FAIL dbg_overflow got %b want 0", ovf_d);
    else n_pass++;
    for (int i = 0; i < 60000 && dd_rx.size() < seq.size(); i++) @(negedge clk);
    for (int i = 0; i < 2000 && busy_d; i++) @(negedge clk);
    n_checks++;
    if (dd_rx.size() != seq.size() || dd_ferr != 0 || busy_d !== 1'b0 || lvl_d !== 6'd0)
      $display("FAIL dbg_frames got frames,ferr,busy,lvl=%0d,%0d,%b,%0d want 23,0,0,0",
               dd_rx.size(), dd_ferr, busy_d, lvl_d);
    else n_pass++;
    for (int i = 0; i < seq.size() && i < dd_rx.size(); i++) begin
      n_checks++;
      if (dd_rx[i] !== seq[i]) $display("FAIL dbg_byte%0d got %h want %h", i, dd_rx[i], seq[i]);
      else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (dd_start[i] - dd_start[i-1] != 10 * CD + 1)
          $display("FAIL dbg_period%0d got %0d want %0d", i, dd_start[i] - dd_start[i-1], 10 * CD + 1);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
    reset_dut();
    test_debug_sequence();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
